// File: rtl/wb_master_bridge.sv
// -----------------------------------------------------------------------------
// wb_master_bridge
//
// Purpose:
//   Wishbone classic initiator for on-chip test/debug logic. Each command taken
//   on the valid/ready command port becomes exactly one single-beat Wishbone
//   cycle on the user project's slave bus. The outcome (read data or status)
//   is returned on a valid/ready response port. Only one transaction is in
//   flight at a time: IDLE -> BUS -> RESP -> IDLE.
//
// Parameters:
//   ADDR_W          Wishbone address width
//   DATA_W          Wishbone data width (select width is DATA_W/8)
//   TIMEOUT_CYCLES  ack wait limit in BUS cycles, 1..65535 (timeout build only)
//
// Optional feature (compile-time macro):
//   WBM_TIMEOUT_EN  when defined, a 16-bit counter aborts a BUS phase that
//                   sees no ack for TIMEOUT_CYCLES cycles and reports
//                   rsp_err=1. When undefined, no counter exists, rsp_err is
//                   constant 0 and BUS waits for ack indefinitely.
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock; asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_we/adr/dat/sel           command payload (1 = write)
//   rsp_valid/rsp_ready          response handshake
//   rsp_dat, rsp_err             read data (0 for writes/timeouts), timeout flag
//   wbm_cyc_o/stb_o/we_o/adr_o/dat_o/sel_o   registered Wishbone outputs
//   wbm_dat_i, wbm_ack_i                     Wishbone returns
// -----------------------------------------------------------------------------
module wb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_adr,
  input  logic [DATA_W-1:0]   cmd_dat,
  input  logic [DATA_W/8-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  input  logic                wbm_ack_i
);

  localparam int SEL_W = DATA_W / 8;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_master_bridge: TIMEOUT_CYCLES must be within 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                cmd_ready_d;
  logic                cyc_d, stb_d, we_d;
  logic [ADDR_W-1:0]   adr_d;
  logic [DATA_W-1:0]   dat_d;
  logic [SEL_W-1:0]    sel_d;
  logic                rsp_valid_d;
  logic [DATA_W-1:0]   rsp_dat_d;
  logic                rsp_err_d;

`ifdef WBM_TIMEOUT_EN
  // The last BUS cycle allowed without ack is the one in which the counter
  // would step up to TIMEOUT_CYCLES, so cyc stays high exactly that many cycles.
  localparam logic [15:0] TERM_CNT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready;
    cyc_d       = wbm_cyc_o;
    stb_d       = wbm_stb_o;
    we_d        = wbm_we_o;
    adr_d       = wbm_adr_o;
    dat_d       = wbm_dat_o;
    sel_d       = wbm_sel_o;
    rsp_valid_d = rsp_valid;
    rsp_dat_d   = rsp_dat;
    rsp_err_d   = rsp_err;
`ifdef WBM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        // cmd_ready is registered, so it rises on the first edge after reset.
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_d = 1'b0;
          we_d        = cmd_we;
          adr_d       = cmd_adr;
          dat_d       = cmd_dat;
          sel_d       = cmd_sel;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          state_d     = BUS;
`ifdef WBM_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end

      BUS: begin
        cmd_ready_d = 1'b0;
        if (wbm_ack_i) begin
          // Ack takes priority over a coinciding terminal count.
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = wbm_we_o ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end
`ifdef WBM_TIMEOUT_EN
        else if (cnt_q == TERM_CNT) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end

      RESP: begin
        // No command overlap: cmd_ready only returns after the response leaves.
        cmd_ready_d = 1'b0;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b0;
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything, including the
  // in-flight command and any pending response.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      cmd_ready <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= cmd_ready_d;
      wbm_cyc_o <= cyc_d;
      wbm_stb_o <= stb_d;
      wbm_we_o  <= we_d;
      wbm_adr_o <= adr_d;
      wbm_dat_o <= dat_d;
      wbm_sel_o <= sel_d;
      rsp_valid <= rsp_valid_d;
      rsp_dat   <= rsp_dat_d;
    end
  end

`ifdef WBM_TIMEOUT_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q   <= '0;
      rsp_err <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rsp_err <= rsp_err_d;
    end
  end
`else
  assign rsp_err = 1'b0;

  // Without the timeout there is no error source; the next-value term stays
  // constant and is deliberately left unconnected.
  logic unused_rsp_err_d;
  assign unused_rsp_err_d = rsp_err_d;
`endif

endmodule
